// File: rtl/serial_div_pkg.sv
// Shared definitions for the Wishbone iterative divider.
// Register offsets, CTRL/STATUS bit positions and FSM states.
package serial_div_pkg;

    localparam logic [2:0] ADR_DIVIDEND = 3'd0;
    localparam logic [2:0] ADR_DIVISOR  = 3'd1;
    localparam logic [2:0] ADR_QUOT     = 3'd2;
    localparam logic [2:0] ADR_REM      = 3'd3;
    localparam logic [2:0] ADR_CTRL     = 3'd4;
    localparam logic [2:0] ADR_STATUS   = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_DEBUG  = 2;
    localparam int CTRL_IE     = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_DIV0 = 2;
    localparam int ST_OVF  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    typedef enum logic [1:0] {
        P_NORM,
        P_DIV0,
        P_OVF
    } path_t;

    // Byte-lane merge of a 32-bit write into an existing word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = sel[i] ? dat[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction

endpackage

// File: rtl/serial_divider_v2_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// valid marks the final step; q/r then carry the finished result.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r,
    output logic            valid
);

    localparam int CW = $clog2(XLEN);

    logic            run;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   t;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] q_n;
    logic [XLEN-1:0] r_n;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        t    = {rem_q, quo_q[XLEN-1]};
        diff = t - {1'b0, b_q};
        ge   = !diff[XLEN];
        q_n  = {quo_q[XLEN-2:0], ge};
        r_n  = ge ? diff[XLEN-1:0] : t[XLEN-1:0];
    end

    assign q     = q_n;
    assign r     = r_n;
    assign valid = run && (cnt == '0);

    // Load operands on start, then shift one quotient bit in per cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            run   <= 1'b0;
            cnt   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
        end else if (start) begin
            run   <= 1'b1;
            cnt   <= CW'(XLEN - 1);
            quo_q <= a;
            rem_q <= '0;
            b_q   <= b;
        end else if (run) begin
            quo_q <= q_n;
            rem_q <= r_n;
            cnt   <= cnt - 1'b1;
            if (cnt == '0)
                run <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_divider_v2.sv
// Wishbone-slave iterative integer divider with signed mode,
// sticky status flags, interrupt and logic-analyser mirror.
module serial_divider_v2
    import serial_div_pkg::*;
#(
    parameter int WBW  = 32,
    parameter int XLEN = 32,
    parameter int LAW  = 4 * XLEN
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [WBW/8-1:0] wbs_sel_i,
    input  logic [WBW-1:0]   wbs_adr_i,
    input  logic [WBW-1:0]   wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [WBW-1:0]   wbs_dat_o,
    output logic [LAW-1:0]   la_data_o,
    output logic             irq_o
);

    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    path_t           path;
    logic [XLEN-1:0] dividend, divisor, quotient, remainder;
    logic [XLEN-1:0] uq, ur, abs_a, abs_b;
    logic [XLEN-1:0] core_q, core_r;
    logic            core_valid, core_start;
    logic            c_signed, c_debug, c_ie;
    logic            s_done, s_div0, s_ovf;
    logic            neg_q, neg_r, a_neg, b_neg;
    logic            div0_c, ovf_c;
    logic            acc, wr, rd, idle, start_req;
    logic [2:0]      adr;
    logic [WBW-1:0]  rdata;
    logic            unused_adr;

    function automatic logic [WBW-1:0] zext(input logic [XLEN-1:0] v);
        logic [WBW-1:0] e;
        e = '0;
        e[XLEN-1:0] = v;
        return e;
    endfunction

    function automatic logic [XLEN-1:0] lane(
        input logic [XLEN-1:0] old,
        input logic [WBW-1:0]  dat,
        input logic [3:0]      sel
    );
        logic [31:0] m;
        m = byte_merge(zext(old), dat, sel);
        return m[XLEN-1:0];
    endfunction

    assign adr        = wbs_adr_i[4:2];
    assign unused_adr = ^{wbs_adr_i[WBW-1:5], wbs_adr_i[1:0]};
    assign acc        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr         = acc & wbs_we_i;
    assign rd         = acc & ~wbs_we_i;
    assign idle       = (state == S_IDLE);
    assign start_req  = wr && (adr == ADR_CTRL) && wbs_sel_i[0]
                        && wbs_dat_i[CTRL_START];

    assign a_neg  = c_signed & dividend[XLEN-1];
    assign b_neg  = c_signed & divisor[XLEN-1];
    assign abs_a  = a_neg ? -dividend : dividend;
    assign abs_b  = b_neg ? -divisor : divisor;
    assign div0_c = (divisor == '0);
    assign ovf_c  = c_signed && (dividend == MIN) && (divisor == '1);

    assign core_start = (state == S_PREP) && !div0_c && !ovf_c;

    assign la_data_o = {dividend, divisor, quotient, remainder};
    assign irq_o     = s_done & c_ie;

    div_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .start    (core_start),
        .a        (abs_a),
        .b        (abs_b),
        .q        (core_q),
        .r        (core_r),
        .valid    (core_valid)
    );

    // Read-data mux; unmapped offsets return zero.
    always_comb begin
        rdata = '0;
        unique case (adr)
            ADR_DIVIDEND: rdata = zext(dividend);
            ADR_DIVISOR:  rdata = zext(divisor);
            ADR_QUOT:     rdata = zext(quotient);
            ADR_REM:      rdata = zext(remainder);
            ADR_CTRL: begin
                rdata[CTRL_SIGNED] = c_signed;
                rdata[CTRL_DEBUG]  = c_debug;
                rdata[CTRL_IE]     = c_ie;
            end
            ADR_STATUS: begin
                rdata[ST_BUSY] = !idle;
                rdata[ST_DONE] = s_done;
                rdata[ST_DIV0] = s_div0;
                rdata[ST_OVF]  = s_ovf;
            end
            default: rdata = '0;
        endcase
    end

    // Single-cycle acknowledge and registered read data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc;
            if (acc)
                wbs_dat_o <= rd ? rdata : '0;
        end
    end

    // Register writes and FSM; FSM updates come last so FIX beats a W1C.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= S_IDLE;
            path      <= P_NORM;
            dividend  <= '0;
            divisor   <= '0;
            quotient  <= '0;
            remainder <= '0;
            uq        <= '0;
            ur        <= '0;
            c_signed  <= 1'b0;
            c_debug   <= 1'b0;
            c_ie      <= 1'b0;
            s_done    <= 1'b0;
            s_div0    <= 1'b0;
            s_ovf     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            if (wr) begin
                unique case (adr)
                    ADR_DIVIDEND:
                        if (idle)
                            dividend <= lane(dividend, wbs_dat_i, wbs_sel_i);
                    ADR_DIVISOR:
                        if (idle)
                            divisor <= lane(divisor, wbs_dat_i, wbs_sel_i);
                    ADR_QUOT:
                        if (idle && c_debug)
                            quotient <= lane(quotient, wbs_dat_i, wbs_sel_i);
                    ADR_REM:
                        if (idle && c_debug)
                            remainder <= lane(remainder, wbs_dat_i, wbs_sel_i);
                    ADR_CTRL:
                        if (wbs_sel_i[0]) begin
                            if (idle)
                                c_signed <= wbs_dat_i[CTRL_SIGNED];
                            c_debug <= wbs_dat_i[CTRL_DEBUG];
                            c_ie    <= wbs_dat_i[CTRL_IE];
                        end
                    ADR_STATUS:
                        if (wbs_sel_i[0]) begin
                            if (wbs_dat_i[ST_DONE]) s_done <= 1'b0;
                            if (wbs_dat_i[ST_DIV0]) s_div0 <= 1'b0;
                            if (wbs_dat_i[ST_OVF])  s_ovf  <= 1'b0;
                        end
                    default: ;
                endcase
            end

            unique case (state)
                S_IDLE:
                    if (start_req)
                        state <= S_PREP;
                S_PREP: begin
                    s_done <= 1'b0;
                    s_div0 <= 1'b0;
                    s_ovf  <= 1'b0;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    if (div0_c) begin
                        path  <= P_DIV0;
                        state <= S_FIX;
                    end else if (ovf_c) begin
                        path  <= P_OVF;
                        state <= S_FIX;
                    end else begin
                        path  <= P_NORM;
                        state <= S_CALC;
                    end
                end
                S_CALC:
                    if (core_valid) begin
                        uq    <= core_q;
                        ur    <= core_r;
                        state <= S_FIX;
                    end
                S_FIX: begin
                    unique case (path)
                        P_DIV0: begin
                            quotient  <= '1;
                            remainder <= dividend;
                            s_div0    <= 1'b1;
                        end
                        P_OVF: begin
                            quotient  <= MIN;
                            remainder <= '0;
                            s_ovf     <= 1'b1;
                        end
                        default: begin
                            quotient  <= neg_q ? -uq : uq;
                            remainder <= neg_r ? -ur : ur;
                        end
                    endcase
                    s_done <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_divider_v2.sv
// Scoreboard bench for serial_divider_v2 with directed vectors.
// Reads push expectations; a negedge monitor pops them on read acks.
module tb_serial_divider_v2;

    localparam int XLEN = 32;
    localparam logic [31:0] A_DVD  = 32'h00;
    localparam logic [31:0] A_DVS  = 32'h04;
    localparam logic [31:0] A_Q    = 32'h08;
    localparam logic [31:0] A_R    = 32'h0C;
    localparam logic [31:0] A_CTRL = 32'h10;
    localparam logic [31:0] A_ST   = 32'h14;

    logic         clk_i = 1'b0;
    logic         reset_ni = 1'b0;
    logic         wbs_stb_i = 1'b0;
    logic         wbs_cyc_i = 1'b0;
    logic         wbs_we_i = 1'b0;
    logic [3:0]   wbs_sel_i = 4'h0;
    logic [31:0]  wbs_adr_i = '0;
    logic [31:0]  wbs_dat_i = '0;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic [127:0] la_data_o;
    logic         irq_o;

    string        nm_q[$];
    logic [31:0]  exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           k;

    always #5 clk_i = ~clk_i;

    serial_divider_v2 #(.WBW(32), .XLEN(XLEN), .LAW(4*XLEN)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .la_data_o (la_data_o),
        .irq_o     (irq_o)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (reset_ni && wbs_ack_o && !wbs_we_i) begin
            if (nm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %0h expected none",
                         wbs_dat_o);
            end else begin
                chk(nm_q.pop_front(), {96'd0, wbs_dat_o},
                    {96'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wb_cycle(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        int n;
        @(negedge clk_i);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!wbs_ack_o && n < 8);
        if (!wbs_ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack adr %0h", adr);
        end
        #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        wb_cycle(1'b1, adr, dat, 4'hF);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp,
                      input string nm);
        nm_q.push_back(nm);
        exp_q.push_back(exp);
        wb_cycle(1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic wait_irq(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!irq_o && cyc < 200);
        if (!irq_o) begin
            checks++;
            errors++;
            $display("FAIL irq_timeout: got irq 0 expected 1");
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ctrl, output int cyc);
        wr(A_DVD, a);
        wr(A_DVS, b);
        wr(A_CTRL, ctrl);
        wait_irq(cyc);
    endtask

    task automatic read_all_zero(input string tag);
        rd(A_DVD,  32'h0, {tag, "_dividend"});
        rd(A_DVS,  32'h0, {tag, "_divisor"});
        rd(A_Q,    32'h0, {tag, "_quotient"});
        rd(A_R,    32'h0, {tag, "_remainder"});
        rd(A_CTRL, 32'h0, {tag, "_ctrl"});
        rd(A_ST,   32'h0, {tag, "_status"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_ack", 128'(wbs_ack_o), 128'd0);
        chk("rst_irq", 128'(irq_o), 128'd0);
        chk("rst_la", la_data_o, 128'd0);
        reset_ni = 1'b1;
        read_all_zero("rst");

        wr(A_DVD, 32'd100);
        wr(A_DVS, 32'd7);
        wr(A_CTRL, 32'h9);
        wait_irq(k);
        chk("lat_unsigned", 128'(k), 128'd34);
        chk("irq_done", 128'(irq_o), 128'd1);
        chk("la_mirror", la_data_o, {32'd100, 32'd7, 32'd14, 32'd2});
        rd(A_Q, 32'd14, "u_quot");
        rd(A_R, 32'd2, "u_rem");
        rd(A_ST, 32'h2, "u_status");
        rd(A_CTRL, 32'h8, "u_ctrl");

        run(32'hFFFF_FF9C, 32'd7, 32'hB, k);
        chk("lat_signed", 128'(k), 128'd34);
        rd(A_Q, 32'hFFFF_FFF2, "s1_quot");
        rd(A_R, 32'hFFFF_FFFE, "s1_rem");
        run(32'd100, 32'hFFFF_FFF9, 32'hB, k);
        rd(A_Q, 32'hFFFF_FFF2, "s2_quot");
        rd(A_R, 32'd2, "s2_rem");
        rd(A_CTRL, 32'hA, "s_ctrl");

        run(32'd5, 32'd0, 32'h9, k);
        chk("lat_div0", 128'(k), 128'd2);
        rd(A_Q, 32'hFFFF_FFFF, "d0_quot");
        rd(A_R, 32'd5, "d0_rem");
        rd(A_ST, 32'h6, "d0_status");
        wr(A_ST, 32'h6);
        rd(A_ST, 32'h0, "d0_w1c");
        chk("d0_irq_clr", 128'(irq_o), 128'd0);

        run(32'h8000_0000, 32'hFFFF_FFFF, 32'hB, k);
        chk("lat_ovf", 128'(k), 128'd2);
        rd(A_Q, 32'h8000_0000, "ovf_quot");
        rd(A_R, 32'h0, "ovf_rem");
        rd(A_ST, 32'hA, "ovf_status");

        wr(A_DVD, 32'd1000);
        wr(A_DVS, 32'd3);
        wr(A_CTRL, 32'h9);
        wr(A_DVD, 32'd9);
        wr(A_CTRL, 32'h9);
        rd(A_DVD, 32'd1000, "busy_dividend");
        rd(A_ST, 32'h1, "busy_status");
        wait_irq(k);
        rd(A_Q, 32'd333, "busy_quot");
        rd(A_R, 32'd1, "busy_rem");
        wr(A_ST, 32'h2);
        repeat (40) @(negedge clk_i);
        rd(A_ST, 32'h0, "busy_single_done");

        wr(A_CTRL, 32'hC);
        wr(A_Q, 32'h1234);
        rd(A_Q, 32'h1234, "dbg_quot");
        wr(A_CTRL, 32'h8);
        wr(A_Q, 32'h5678);
        rd(A_Q, 32'h1234, "nodbg_quot");
        wr(A_DVD, 32'h0);
        wb_cycle(1'b1, A_DVD, 32'h1122_3344, 4'b0101);
        rd(A_DVD, 32'h0022_0044, "byte_lanes");
        wr(32'h1C, 32'hFFFF_FFFF);
        rd(32'h18, 32'h0, "unmapped_18");
        rd(32'h1C, 32'h0, "unmapped_1c");

        wr(A_DVD, 32'd1000);
        wr(A_DVS, 32'd3);
        wr(A_CTRL, 32'h9);
        repeat (11) @(negedge clk_i);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_ack", 128'(wbs_ack_o), 128'd0);
        chk("mid_rst_irq", 128'(irq_o), 128'd0);
        chk("mid_rst_la", la_data_o, 128'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        read_all_zero("mid_rst");
        run(32'h55, 32'h5, 32'h9, k);
        chk("lat_after_rst", 128'(k), 128'd34);
        rd(A_Q, 32'd17, "after_rst_quot");
        rd(A_R, 32'd0, "after_rst_rem");

        repeat (2) @(negedge clk_i);
        chk("sb_drained", 128'(nm_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
